// File: rtl/dot_prod_host_seq.sv
// Host-side sequencer for the dot-product kernel: streams N operand pairs into
// arr_a/arr_b, kicks the kernel, and returns its 64-bit result under a watchdog.
module dot_prod_host_seq #(
  parameter int N       = 1000,
  parameter int AW      = 10,
  parameter int DW      = 27,
  parameter int TIMEOUT = 16383,
  parameter int TW      = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_a,
  input  logic [DW-1:0] load_b,
  input  logic          start,
  output logic          busy,
  output logic          controlArr,
  output logic          controlArrWEnable_a,
  output logic [AW-1:0] controlArrAddr_a,
  output logic [DW-1:0] controlArrWData_a,
  output logic          controlArrWEnable_b,
  output logic [AW-1:0] controlArrAddr_b,
  output logic [DW-1:0] controlArrWData_b,
  output logic          r_enable,
  output logic [63:0]   init_i,
  output logic [63:0]   init_acc,
  input  logic          w_enable,
  input  logic [63:0]   result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic          res_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KICK = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The load pointer needs one extra bit so that it can hold N == 2**AW.
  localparam logic [AW:0]   N_C       = N[AW:0];
  localparam logic [TW-1:0] TIMEOUT_C = TIMEOUT[TW-1:0];

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [63:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;

  logic          is_idle_s;
  logic          kernel_owns_s;
  logic          accept_s;
  logic [TW-1:0] wdog_inc_s;

  assign is_idle_s     = (state_q == S_IDLE);
  assign kernel_owns_s = (state_q == S_KICK) || (state_q == S_RUN);
  assign wdog_inc_s    = wdog_q + 1'b1;

  // Outputs decode straight from state so an async reset takes effect in the same cycle.
  assign load_ready = is_idle_s && (cnt_q < N_C);
  assign accept_s   = load_valid && load_ready;
  assign busy       = kernel_owns_s;
  assign controlArr = ~kernel_owns_s;
  assign r_enable   = (state_q == S_KICK);
  assign res_valid  = (state_q == S_DONE);
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign init_i     = 64'd0;
  assign init_acc   = 64'd0;

  assign controlArrWEnable_a = accept_s;
  assign controlArrWEnable_b = accept_s;
  assign controlArrAddr_a    = cnt_q[AW-1:0];
  assign controlArrAddr_b    = cnt_q[AW-1:0];
  assign controlArrWData_a   = load_a;
  assign controlArrWData_b   = load_b;

  // Next-state, load pointer, watchdog and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
        if (start && (cnt_q == N_C)) begin
          state_d = S_KICK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KICK: begin
        wdog_d  = {TW{1'b0}};
        state_d = S_RUN;
      end
      S_RUN: begin
        // The watchdog counts the current RUN cycle; a late w_enable still beats the abort.
        wdog_d = wdog_inc_s;
        if (w_enable) begin
          res_data_d = result;
          res_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (wdog_inc_s == TIMEOUT_C) begin
          res_data_d = 64'd0;
          res_err_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          cnt_d   = {(AW+1){1'b0}};
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {(AW+1){1'b0}};
      wdog_q     <= {TW{1'b0}};
      res_data_q <= 64'd0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule

// File: tb/tb_dot_prod_host_seq.sv
// Self-checking bench for dot_prod_host_seq: a behavioural kernel stub owns the
// arrays; expected results come from the operand queues the bench itself pushed.
module tb_dot_prod_host_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [26:0] load_a = 27'd0;
  logic [26:0] load_b = 27'd0;
  logic        start = 1'b0;
  logic        busy;
  logic        controlArr;
  logic        controlArrWEnable_a;
  logic [9:0]  controlArrAddr_a;
  logic [26:0] controlArrWData_a;
  logic        controlArrWEnable_b;
  logic [9:0]  controlArrAddr_b;
  logic [26:0] controlArrWData_b;
  logic        r_enable;
  logic [63:0] init_i;
  logic [63:0] init_acc;
  logic        w_enable;
  logic [63:0] result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        res_err;

  int checks = 0;
  int errors = 0;

  logic signed [26:0] mem_a [0:1023];
  logic signed [26:0] mem_b [0:1023];
  int                 wr_log[$];
  logic signed [26:0] ref_a[$];
  logic signed [26:0] ref_b[$];

  bit kern_hang  = 1'b0;
  bit kern_noise = 1'b0;
  int kern_lat   = 3;
  int kcnt;
  bit kbusy;

  dot_prod_host_seq dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_a(load_a), .load_b(load_b),
    .start(start), .busy(busy), .controlArr(controlArr),
    .controlArrWEnable_a(controlArrWEnable_a), .controlArrAddr_a(controlArrAddr_a),
    .controlArrWData_a(controlArrWData_a),
    .controlArrWEnable_b(controlArrWEnable_b), .controlArrAddr_b(controlArrAddr_b),
    .controlArrWData_b(controlArrWData_b),
    .r_enable(r_enable), .init_i(init_i), .init_acc(init_acc),
    .w_enable(w_enable), .result(result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Array model: writes land only while the sequencer owns the arrays.
  always @(posedge clk) begin
    if (!rst && controlArr && controlArrWEnable_a) begin
      mem_a[controlArrAddr_a] <= controlArrWData_a;
      wr_log.push_back(int'(controlArrAddr_a));
    end
    if (!rst && controlArr && controlArrWEnable_b) begin
      mem_b[controlArrAddr_b] <= controlArrWData_b;
    end
  end

  function automatic logic [63:0] kernel_sum();
    logic signed [63:0] s;
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    s = 64'sd0;
    for (int i = 0; i < 1000; i++) begin
      xa = mem_a[i];
      xb = mem_b[i];
      s  = s + xa * xb;
    end
    return s;
  endfunction

  function automatic logic [63:0] ref_sum();
    logic signed [63:0] s;
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    s = 64'sd0;
    for (int i = 0; i < ref_a.size(); i++) begin
      xa = ref_a[i];
      xb = ref_b[i];
      s  = s + xa * xb;
    end
    return s;
  endfunction

  // Kernel stub: restarts on r_enable, answers after kern_lat cycles unless hung.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_enable <= 1'b0;
      result   <= 64'd0;
      kbusy    <= 1'b0;
      kcnt     <= 0;
    end else if (r_enable) begin
      w_enable <= 1'b0;
      kbusy    <= 1'b1;
      kcnt     <= kern_lat;
    end else if (kbusy) begin
      if (!kern_hang) begin
        if (kcnt == 0) begin
          w_enable <= 1'b1;
          result   <= kernel_sum();
          kbusy    <= 1'b0;
        end else begin
          kcnt <= kcnt - 1;
        end
      end
    end else if (kern_noise) begin
      result <= ~result;
    end
  end

  task automatic push(input logic [26:0] a, input logic [26:0] b);
    load_valid = 1'b1;
    load_a = a;
    load_b = b;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    ref_a.push_back(a);
    ref_b.push_back(b);
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_random(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      push(27'($urandom), 27'($urandom));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [63:0] exp, input logic exp_err, input string name,
                           output int runc);
    int n;
    runc = 0;
    n = 0;
    @(negedge clk);
    checks++;
    if ({busy, r_enable, controlArr, load_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_kick got %b exp 1100", name, {busy, r_enable, controlArr, load_ready});
    end
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (res_valid === 1'b1) break;
      if (busy === 1'b1 && r_enable === 1'b0) runc++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got res_valid=%b exp 1", name, res_valid);
    end
    checks++;
    if (res_data !== exp) begin
      errors++;
      $display("FAIL %s_data got %0h exp %0h", name, res_data, exp);
    end
    checks++;
    if (res_err !== exp_err) begin
      errors++;
      $display("FAIL %s_err got %b exp %b", name, res_err, exp_err);
    end
    checks++;
    if ({controlArr, busy, load_ready} !== 3'b100) begin
      errors++;
      $display("FAIL %s_done_ctl got %b exp 100", name, {controlArr, busy, load_ready});
    end
  endtask

  task automatic release_result(input string name);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({res_valid, busy, load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL %s_release got %b exp 001", name, {res_valid, busy, load_ready});
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({load_ready, controlArr, r_enable, busy, res_valid, res_err,
         controlArrWEnable_a, controlArrWEnable_b} !== 8'b11000000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 11000000", {load_ready, controlArr, r_enable, busy,
               res_valid, res_err, controlArrWEnable_a, controlArrWEnable_b});
    end
    checks++;
    if (res_data !== 64'd0 || init_i !== 64'd0 || init_acc !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got %0h/%0h/%0h exp 0", res_data, init_i, init_acc);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_ready, busy, controlArrAddr_a} !== {1'b1, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL reset_release got %b exp 100000000000", {load_ready, busy, controlArrAddr_a});
    end
  endtask

  task automatic test_ramp();
    int runc;
    ref_a.delete();
    ref_b.delete();
    kern_lat = 4;
    for (int i = 0; i < 1000; i++) push(27'(i), 27'd2);
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_full got load_ready=%b exp 0", load_ready);
    end
    pulse_start();
    wait_done(64'd999000, 1'b0, "ramp", runc);
    release_result("ramp");
  endtask

  task automatic test_gaps();
    int runc;
    int base;
    int bad;
    ref_a.delete();
    ref_b.delete();
    kern_lat = 0;
    base = wr_log.size();
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0 && i != 0) idle(1);
      push(27'h7FFFFFF, 27'd3);
    end
    @(negedge clk);
    checks++;
    if (wr_log.size() - base !== 1000) begin
      errors++;
      $display("FAIL gaps_wr_count got %0d exp 1000", wr_log.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 1000 && base + i < wr_log.size(); i++) begin
      if (wr_log[base + i] != i) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gaps_wr_order got %0d out-of-order exp 0", bad);
    end
    pulse_start();
    wait_done(-64'sd3000, 1'b0, "gaps", runc);
    release_result("gaps");
  endtask

  task automatic test_early_start();
    int runc;
    int base;
    ref_a.delete();
    ref_b.delete();
    kern_lat = 7;
    load_random(0, 500);
    base = wr_log.size();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, load_ready, controlArr, controlArrWEnable_a, controlArrAddr_a}
          !== {1'b0, 1'b1, 1'b1, 1'b0, 10'd500}) begin
        errors++;
        $display("FAIL early_start_ignored got %b exp 0110%b", {busy, load_ready, controlArr,
                 controlArrWEnable_a, controlArrAddr_a}, 10'd500);
      end
    end
    checks++;
    if (wr_log.size() !== base) begin
      errors++;
      $display("FAIL early_start_writes got %0d exp %0d", wr_log.size(), base);
    end
    load_random(500, 500);
    load_valid = 1'b1;
    load_a = 27'd5;
    load_b = 27'd5;
    @(negedge clk);
    checks++;
    if ({load_ready, controlArrWEnable_a, controlArrWEnable_b, controlArrAddr_b}
        !== {1'b0, 1'b0, 1'b0, 10'd1000}) begin
      errors++;
      $display("FAIL saturate got %b exp 000%b", {load_ready, controlArrWEnable_a,
               controlArrWEnable_b, controlArrAddr_b}, 10'd1000);
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
    pulse_start();
    wait_done(ref_sum(), 1'b0, "early", runc);
    release_result("early");
  endtask

  task automatic test_hold();
    int runc;
    logic [63:0] exp;
    ref_a.delete();
    ref_b.delete();
    kern_lat = 2;
    load_random(0, 1000);
    exp = ref_sum();
    kern_noise = 1'b1;
    pulse_start();
    wait_done(exp, 1'b0, "hold", runc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_err} !== 2'b10 || res_data !== exp) begin
        errors++;
        $display("FAIL hold_stable got v=%b e=%b d=%0h exp v=1 e=0 d=%0h",
                 res_valid, res_err, res_data, exp);
      end
    end
    kern_noise = 1'b0;
    release_result("hold");
  endtask

  task automatic test_timeout();
    int runc;
    ref_a.delete();
    ref_b.delete();
    load_random(0, 1000);
    kern_hang = 1'b1;
    pulse_start();
    wait_done(64'd0, 1'b1, "timeout", runc);
    checks++;
    if (runc !== 16383) begin
      errors++;
      $display("FAIL timeout_cycles got %0d exp 16383", runc);
    end
    release_result("timeout");
    kern_hang = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int runc;
    int base;
    ref_a.delete();
    ref_b.delete();
    load_random(0, 1000);
    kern_hang = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({controlArr, busy, r_enable, res_valid, load_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL midrun_reset got %b exp 10001", {controlArr, busy, r_enable, res_valid, load_ready});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    kern_hang = 1'b0;
    ref_a.delete();
    ref_b.delete();
    kern_lat = 5;
    base = wr_log.size();
    load_random(0, 1000);
    @(negedge clk);
    checks++;
    if (wr_log.size() - base !== 1000 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reload got %0d writes ready=%b exp 1000 ready=0",
               wr_log.size() - base, load_ready);
    end
    pulse_start();
    wait_done(ref_sum(), 1'b0, "midrun", runc);
    release_result("midrun");
  endtask

  task automatic test_random();
    int runc;
    for (int r = 0; r < 2; r++) begin
      ref_a.delete();
      ref_b.delete();
      kern_lat = $urandom_range(0, 12);
      load_random(0, 1000);
      idle($urandom_range(0, 4));
      pulse_start();
      wait_done(ref_sum(), 1'b0, "random", runc);
      release_result("random");
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_early_start();
    test_hold();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
